// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a 3-state fetch FSM.
// Optional hardware return stack enabled by defining FETCH_RET_STACK_EN.
module fetch_unit #(
  parameter int unsigned PC_WIDTH    = 11,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_value,
  input  logic                call_push,
  input  logic                ret_pop,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [15:0]         ir,
  output logic [4:0]          opcode,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                fetch_done,
  output logic                stack_err
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;

`ifdef FETCH_RET_STACK_EN
  localparam int unsigned SpWidth  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IdxWidth = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SpWidth-1:0]  sp_q, sp_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic                stack_err_q, stack_err_d;
  logic                push_en;
  logic [IdxWidth-1:0] push_idx, pop_idx;
  logic                stack_full, stack_empty;

  assign stack_full  = (sp_q == SpWidth'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_idx    = sp_q[IdxWidth-1:0];
  assign pop_idx     = IdxWidth'(sp_q - SpWidth'(1));
`else
  logic unused_ret_pop;
  assign unused_ret_pop = ret_pop;
  logic unused_depth;
  assign unused_depth = (STACK_DEPTH == 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_RET_STACK_EN
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    push_en     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Commands are mutually exclusive per cycle: ret_pop > call_push > pc_load > fetch_req.
`ifdef FETCH_RET_STACK_EN
        if (ret_pop) begin
          if (stack_empty) begin
            stack_err_d = 1'b1;
          end else begin
            sp_d = sp_q - SpWidth'(1);
            pc_d = stack_q[pop_idx];
          end
        end else if (call_push) begin
          if (stack_full) begin
            stack_err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SpWidth'(1);
            pc_d    = pc_value;
          end
        end else
`else
        if (call_push) begin
          pc_d = pc_value;
        end else
`endif
        if (pc_load) begin
          pc_d = pc_value;
        end else if (fetch_req) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_RET_STACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Entries need no reset: sp gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_q[push_idx] <= pc_q;
    end
  end

  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == StReq);
  assign busy       = (state_q != StIdle);
  assign fetch_done = (state_q == StDone);
  assign ir         = ir_q;
  assign opcode     = ir_q[15:11];
  assign pc         = pc_q;

endmodule
